// File: rtl/cipher_mon_pkg.sv
// ============================================================================
// Module : cipher_mon_pkg
// Purpose: Shared definitions for the cipher stream monitor: run-state
//          encoding, default parameter values and a pointer-width helper.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cipher_mon_pkg;

  localparam int DEF_DATA_W = 128;
  localparam int DEF_DEPTH  = 64;
  localparam int DEF_CNT_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_FAIL = 2'd3
  } mon_state_e;

  // Pointer width for a power-of-two FIFO; never below one bit.
  function automatic int addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ts_fifo.sv
// ============================================================================
// Module : ts_fifo
// Purpose: Synchronous show-ahead FIFO holding input timestamps. A pop is
//          judged against the occupancy before any same-cycle push, so a
//          push into a full FIFO succeeds when a pop happens in that cycle.
// Ports  : clk, reset (async, active-low)
//          clr_i      - synchronous flush
//          push_i     - write wr_data_i (dropped when full without a pop)
//          pop_i      - advance read pointer (dropped when empty)
//          rd_data_o  - oldest entry
//          full_o / empty_o - occupancy flags
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ts_fifo
  import cipher_mon_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = addr_w(DEPTH);
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic w_pop;
  logic w_push;

  assign full_o  = (count_q == C_FULL);
  assign empty_o = (count_q == '0);

  // Pop uses the pre-push occupancy; a pop frees the slot the push needs.
  assign w_pop  = pop_i && !empty_o;
  assign w_push = push_i && (!full_o || w_pop);

  assign rd_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    if (w_push && !clr_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

`default_nettype wire

// File: rtl/cipher_stream_monitor.sv
// ============================================================================
// Module : cipher_stream_monitor
// Purpose: Watches a cipher core's input/output handshakes, timestamps each
//          accepted input, measures per-block latency, compares each output
//          block with a golden block and accumulates run statistics.
// Ports  : clk, reset (async, active-low)
//          start, num_patterns, stop_on_err   - run control (sampled on start)
//          in_valid, out_valid, out_data, exp_data - observed traffic
//          exp_rd                             - golden-source advance
//          busy, done, pass, overflow         - run status
//          err_count, first_err_idx, in_count, out_count,
//          lat_min, lat_max, lat_sum          - registered statistics
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cipher_stream_monitor
  import cipher_mon_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_patterns,
  input  logic              stop_on_err,
  input  logic              in_valid,
  input  logic              out_valid,
  input  logic [DATA_W-1:0] out_data,
  input  logic [DATA_W-1:0] exp_data,
  output logic              exp_rd,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              overflow,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  first_err_idx,
  output logic [CNT_W-1:0]  in_count,
  output logic [CNT_W-1:0]  out_count,
  output logic [CNT_W-1:0]  lat_min,
  output logic [CNT_W-1:0]  lat_max,
  output logic [CNT_W-1:0]  lat_sum
);

  mon_state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic             stop_q, stop_d;
  logic [CNT_W-1:0] in_count_q, in_count_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [CNT_W-1:0] first_err_idx_q, first_err_idx_d;
  logic [CNT_W-1:0] lat_min_q, lat_min_d;
  logic [CNT_W-1:0] lat_max_q, lat_max_d;
  logic [CNT_W-1:0] lat_sum_q, lat_sum_d;
  logic             overflow_q, overflow_d;

  logic             w_run;
  logic             w_push;
  logic             w_pop_req;
  logic             w_pop;
  logic             w_underflow;
  logic             w_ovf;
  logic             w_mismatch;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [CNT_W-1:0] w_ts;
  logic [CNT_W-1:0] w_lat;
  logic [CNT_W-1:0] w_out_cnt_inc;
  logic [CNT_W:0]   w_sum_ext;

  // Traffic in the start cycle belongs to no run and is dropped.
  assign w_run       = (state_q == ST_RUN) && !start;
  assign w_push      = w_run && in_valid && (in_count_q < num_q);
  assign w_pop_req   = w_run && out_valid;
  assign w_underflow = w_pop_req && w_fifo_empty;
  assign w_pop       = w_pop_req && !w_fifo_empty;
  assign w_ovf       = w_push && w_fifo_full && !w_pop;
  assign w_mismatch  = w_pop && (out_data != exp_data);

  // Modular subtraction gives the right latency across counter wrap.
  assign w_lat         = cnt_q - w_ts;
  assign w_out_cnt_inc = out_count_q + CNT_W'(1);
  assign w_sum_ext     = {1'b0, lat_sum_q} + {1'b0, w_lat};

  ts_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CNT_W)
  ) u_ts_fifo (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (start),
    .push_i    (w_push),
    .pop_i     (w_pop),
    .wr_data_i (cnt_q),
    .rd_data_o (w_ts),
    .full_o    (w_fifo_full),
    .empty_o   (w_fifo_empty)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = (num_patterns == '0) ? ST_DONE : ST_RUN;
    end else if (state_q == ST_RUN) begin
      // A failing final compare under stop_on_err ends in FAIL, not DONE.
      if (w_underflow || w_ovf || (w_mismatch && stop_q)) begin
        state_d = ST_FAIL;
      end else if (w_pop && (w_out_cnt_inc == num_q)) begin
        state_d = ST_DONE;
      end
    end
  end

  // ----------------------------------------------------------- datapath
  always_comb begin
    cnt_d           = cnt_q;
    num_d           = num_q;
    stop_d          = stop_q;
    in_count_d      = in_count_q;
    out_count_d     = out_count_q;
    err_count_d     = err_count_q;
    first_err_idx_d = first_err_idx_q;
    lat_min_d       = lat_min_q;
    lat_max_d       = lat_max_q;
    lat_sum_d       = lat_sum_q;
    overflow_d      = overflow_q;

    if (start) begin
      cnt_d           = '0;
      num_d           = num_patterns;
      stop_d          = stop_on_err;
      in_count_d      = '0;
      out_count_d     = '0;
      err_count_d     = '0;
      first_err_idx_d = '0;
      lat_min_d       = '1;
      lat_max_d       = '0;
      lat_sum_d       = '0;
      overflow_d      = 1'b0;
    end else if (w_run) begin
      cnt_d = cnt_q + CNT_W'(1);
      // A push rejected as overflow is not counted as accepted.
      if (w_push && !w_ovf) in_count_d = in_count_q + CNT_W'(1);
      if (w_underflow || w_ovf) overflow_d = 1'b1;
      if (w_pop) begin
        out_count_d = w_out_cnt_inc;
        if (w_lat < lat_min_q) lat_min_d = w_lat;
        if (w_lat > lat_max_q) lat_max_d = w_lat;
        lat_sum_d = w_sum_ext[CNT_W] ? '1 : w_sum_ext[CNT_W-1:0];
        if (w_mismatch) begin
          // err_count saturates, so zero only ever means "no error yet".
          if (err_count_q == '0) first_err_idx_d = out_count_q;
          if (err_count_q != '1) err_count_d = err_count_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q           <= '0;
      num_q           <= '0;
      stop_q          <= 1'b0;
      in_count_q      <= '0;
      out_count_q     <= '0;
      err_count_q     <= '0;
      first_err_idx_q <= '0;
      lat_min_q       <= '1;
      lat_max_q       <= '0;
      lat_sum_q       <= '0;
      overflow_q      <= 1'b0;
    end else begin
      cnt_q           <= cnt_d;
      num_q           <= num_d;
      stop_q          <= stop_d;
      in_count_q      <= in_count_d;
      out_count_q     <= out_count_d;
      err_count_q     <= err_count_d;
      first_err_idx_q <= first_err_idx_d;
      lat_min_q       <= lat_min_d;
      lat_max_q       <= lat_max_d;
      lat_sum_q       <= lat_sum_d;
      overflow_q      <= overflow_d;
    end
  end

  // ------------------------------------------------------------ outputs
  assign exp_rd        = out_valid && (state_q == ST_RUN);
  assign busy          = (state_q == ST_RUN);
  assign done          = (state_q == ST_DONE) || (state_q == ST_FAIL);
  assign pass          = (state_q == ST_DONE) && (err_count_q == '0) && !overflow_q;
  assign overflow      = overflow_q;
  assign err_count     = err_count_q;
  assign first_err_idx = first_err_idx_q;
  assign in_count      = in_count_q;
  assign out_count     = out_count_q;
  assign lat_min       = lat_min_q;
  assign lat_max       = lat_max_q;
  assign lat_sum       = lat_sum_q;

endmodule

`default_nettype wire

// File: tb/tb_cipher_stream_monitor.sv
// ============================================================================
// Module : tb_cipher_stream_monitor
// Purpose: Directed-vector bench. Each run pushes its hand-computed final
//          statistics into a queue; a monitor pops and compares them when
//          the DUT raises done.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cipher_stream_monitor;

  localparam int DW = 32;
  localparam int DP = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] num_patterns = '0;
  logic          stop_on_err = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_valid = 1'b0;
  logic [DW-1:0] out_data = '0;
  logic [DW-1:0] exp_data = '0;
  logic          exp_rd, busy, done, pass, overflow;
  logic [CW-1:0] err_count, first_err_idx, in_count, out_count;
  logic [CW-1:0] lat_min, lat_max, lat_sum;

  cipher_stream_monitor #(
    .DATA_W (DW),
    .DEPTH  (DP),
    .CNT_W  (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .num_patterns  (num_patterns),
    .stop_on_err   (stop_on_err),
    .in_valid      (in_valid),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .exp_data      (exp_data),
    .exp_rd        (exp_rd),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .overflow      (overflow),
    .err_count     (err_count),
    .first_err_idx (first_err_idx),
    .in_count      (in_count),
    .out_count     (out_count),
    .lat_min       (lat_min),
    .lat_max       (lat_max),
    .lat_sum       (lat_sum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          pass;
    logic          ovf;
    logic [CW-1:0] err;
    logic [CW-1:0] fidx;
    logic [CW-1:0] inc;
    logic [CW-1:0] outc;
    logic [CW-1:0] lmin;
    logic [CW-1:0] lmax;
    logic [CW-1:0] lsum;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  logic done_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: a rising done closes one run; compare against the oldest entry.
  always @(negedge clk) begin
    if (reset && done && !done_prev) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no run end");
      end else begin
        mon_e = sb_q.pop_front();
        check("pass",          pass,          mon_e.pass);
        check("overflow",      overflow,      mon_e.ovf);
        check("err_count",     err_count,     mon_e.err);
        check("first_err_idx", first_err_idx, mon_e.fidx);
        check("in_count",      in_count,      mon_e.inc);
        check("out_count",     out_count,     mon_e.outc);
        check("lat_min",       lat_min,       mon_e.lmin);
        check("lat_max",       lat_max,       mon_e.lmax);
        check("lat_sum",       lat_sum,       mon_e.lsum);
      end
    end
    done_prev = reset ? done : 1'b0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic ov, input logic mism);
    in_valid  = iv;
    out_valid = ov;
    exp_data  = $urandom;
    out_data  = mism ? (exp_data ^ 32'h1) : exp_data;
  endtask

  task automatic cyc(input logic iv, input logic ov, input logic mism);
    drive(iv, ov, mism);
    tick();
  endtask

  task automatic do_start(input logic [CW-1:0] np, input logic stop);
    drive(1'b0, 1'b0, 1'b0);
    start        = 1'b1;
    num_patterns = np;
    stop_on_err  = stop;
    tick();
    start = 1'b0;
  endtask

  task automatic expect_run(input logic p, input logic o, input int err, input int fidx,
                            input int inc, input int outc, input int lmin,
                            input int lmax, input int lsum);
    exp_t e;
    e.pass = p;          e.ovf  = o;
    e.err  = CW'(err);   e.fidx = CW'(fidx);
    e.inc  = CW'(inc);   e.outc = CW'(outc);
    e.lmin = CW'(lmin);  e.lmax = CW'(lmax);
    e.lsum = CW'(lsum);
    sb_q.push_back(e);
  endtask

  // Bounded wait for the monitor to consume all pending run results.
  task automatic wait_sb();
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d pending runs expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no end expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_busy",     busy,      0);
    check("rst_done",     done,      0);
    check("rst_pass",     pass,      0);
    check("rst_overflow", overflow,  0);
    check("rst_lat_min",  lat_min,   255);
    check("rst_in_count", in_count,  0);
    reset = 1'b1;
    tick();
    tick();

    // Nominal: inputs at 0-3, outputs at 41-44 -> latency 41 each
    expect_run(1, 0, 0, 0, 4, 4, 41, 41, 164);
    do_start(4, 0);
    check("busy_run", busy, 1);
    for (int c = 0; c <= 44; c++) begin
      drive(c < 4, c >= 41, 1'b0);
      if (c == 41) begin
        #1;
        check("exp_rd_run", exp_rd, 1);
      end
      tick();
    end
    drive(1'b0, 1'b1, 1'b0);
    #1;
    check("exp_rd_idle", exp_rd, 0);
    tick();
    drive(1'b0, 1'b0, 1'b0);
    wait_sb();

    // Mismatch on output 2, keep running
    expect_run(0, 0, 1, 2, 4, 4, 10, 10, 40);
    do_start(4, 0);
    for (int c = 0; c <= 13; c++) cyc(c < 4, c >= 10, c == 12);
    drive(1'b0, 1'b0, 1'b0);
    wait_sb();

    // Mismatch on output 2, stop on error; trailing output is ignored
    expect_run(0, 0, 1, 2, 4, 3, 10, 10, 30);
    do_start(4, 1);
    for (int c = 0; c <= 13; c++) cyc(c < 4, c >= 10, c == 12);
    drive(1'b0, 1'b0, 1'b0);
    wait_sb();

    // Five inputs into a four-deep FIFO with no outputs
    expect_run(0, 1, 0, 0, 4, 0, 255, 0, 0);
    do_start(8, 0);
    for (int c = 0; c <= 4; c++) cyc(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    wait_sb();

    // Full FIFO with simultaneous push and pop: no overflow, latency 4
    expect_run(1, 0, 0, 0, 6, 6, 4, 4, 24);
    do_start(6, 0);
    for (int c = 0; c <= 9; c++) cyc(c < 6, c >= 4, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    wait_sb();

    // Underflow in the first RUN cycle
    expect_run(0, 1, 0, 0, 0, 0, 255, 0, 0);
    do_start(2, 0);
    cyc(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    wait_sb();

    // Counter wrap: input at 250, output at 260 (counter 4) -> latency 10
    expect_run(1, 0, 0, 0, 1, 1, 10, 10, 10);
    do_start(1, 0);
    for (int c = 0; c <= 260; c++) cyc(c == 250, c == 260, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    wait_sb();

    // Reset mid-run: no done, everything back to reset values
    do_start(4, 0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check("mid_in_count", in_count, 2);
    reset = 1'b0;
    #1;
    check("mrst_busy",     busy,     0);
    check("mrst_done",     done,     0);
    check("mrst_pass",     pass,     0);
    check("mrst_in_count", in_count, 0);
    check("mrst_lat_min",  lat_min,  255);
    check("mrst_overflow", overflow, 0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    check("post_rst_done", done, 0);

    // Empty run: pass on the cycle after start
    expect_run(1, 0, 0, 0, 0, 0, 255, 0, 0);
    do_start(0, 0);
    check("empty_pass", pass, 1);
    wait_sb();

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cipher_stream_monitor.md
CIPHER_STREAM_MONITOR -- requirements
Module: cipher_stream_monitor

Interface
REQ-001 SHALL have parameter DATA_W, default 128, width of the cipher output and expected data.
REQ-002 SHALL have parameter DEPTH, default 64, maximum outstanding inputs; power of two, at least 2.
REQ-003 SHALL have parameter CNT_W, default 32, width of the cycle counter, latencies and counts.
REQ-004 SHALL have port clk, input, 1 bit: clock; all logic is rising-edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: single-cycle pulse that clears statistics and arms a run.
REQ-007 SHALL have port num_patterns, input, CNT_W bits: outputs expected per run, sampled on start.
REQ-008 SHALL have port stop_on_err, input, 1 bit: 1 means the first mismatch ends the run; sampled on start.
REQ-009 SHALL have port in_valid, input, 1 bit: the DUT accepted one input block this cycle.
REQ-010 SHALL have port out_valid, input, 1 bit: the DUT presents one output block this cycle.
REQ-011 SHALL have port out_data, input, DATA_W bits: DUT output block.
REQ-012 SHALL have port exp_data, input, DATA_W bits: golden block for the current output.
REQ-013 SHALL have port exp_rd, output, 1 bit: advances the golden source; combinational, equals out_valid AND state==RUN.
REQ-014 SHALL have ports busy, done and pass, outputs, 1 bit each: run status.
REQ-015 SHALL have port overflow, output, 1 bit: sticky flag for timestamp FIFO overflow or underflow.
REQ-016 SHALL have ports err_count, first_err_idx, in_count, out_count, lat_min, lat_max and lat_sum, outputs, CNT_W bits each.

Function
REQ-017 SHALL implement an FSM with states IDLE, RUN, DONE and FAIL, with these transitions:
- any state to RUN on start;
- RUN to DONE when out_count reaches num_patterns;
- RUN to FAIL on overflow, or on a mismatch while stop_on_err=1.
REQ-018 SHALL enter DONE directly on start with num_patterns=0, asserting pass on the next cycle.
REQ-019 SHALL on start clear all counts, statistics and the FIFO, set lat_min to all-ones, and load cycle counter 0 for the first RUN cycle.
REQ-020 SHALL increment the cycle counter every RUN cycle, wrapping modulo 2^CNT_W.
REQ-021 SHALL in RUN, on in_valid with in_count < num_patterns, push the current counter value into the timestamp FIFO and increment in_count; other in_valid pulses are ignored.
REQ-022 SHALL in RUN, on out_valid, pop one timestamp and compute latency = counter - timestamp modulo 2^CNT_W.
REQ-023 SHALL on each pop update lat_min and lat_max, add the latency to lat_sum (saturating at all-ones), and increment out_count.
REQ-024 SHALL compare out_data against exp_data in the same cycle as the pop; on mismatch:
- increment err_count, saturating;
- capture the out_count value before the increment into first_err_idx, only for the first error of the run.
REQ-025 SHALL evaluate a pop against FIFO occupancy before any same-cycle push.
REQ-026 SHALL treat out_valid with an empty FIFO as underflow: set overflow, discard the compare and statistics updates, go to FAIL.
REQ-027 SHALL, when a push and a pop occur in the same cycle with the FIFO full, perform both and leave occupancy unchanged, without flagging overflow.
REQ-028 SHALL set overflow and go to FAIL on a push when the FIFO is full and no pop occurs.
REQ-029 SHALL register all statistics outputs so they reflect an event on the following cycle; done rises the cycle after the final compare.
REQ-030 SHALL drive status outputs as follows:
- busy = RUN;
- done = DONE or FAIL;
- pass = DONE AND err_count==0 AND overflow==0.
REQ-031 SHALL ignore in_valid and out_valid outside RUN.

Reset
REQ-032 SHALL on reset low force state IDLE, empty the FIFO, zero all outputs except lat_min (all-ones), and clear the cycle counter.
REQ-033 SHALL abort a run on reset mid-run without any done or pass pulse.

Structure
REQ-034 SHALL take the FSM state enum and default parameter constants from shared package cipher_mon_pkg.
REQ-035 SHALL instantiate one sub-module ts_fifo, a synchronous FIFO of DEPTH x CNT_W with full and empty flags and a same-cycle push/pop rule per REQ-025 and REQ-027.

Verification
REQ-036 SHALL cover nominal: start with num_patterns=4; in_valid on counter 0-3; matching out_valid on 41-44 -> done=1, pass=1, lat_min=lat_max=41, lat_sum=164, err_count=0.
REQ-037 SHALL cover mismatch: num_patterns=4 with a mismatch on output 2.
- stop_on_err=0 -> DONE, err_count=1, first_err_idx=2, pass=0.
- stop_on_err=1 -> FAIL after output 2, out_count=3.
REQ-038 SHALL cover FIFO boundaries with DEPTH=4.
- 5 in_valid with no outputs -> overflow=1, FAIL.
- full FIFO with simultaneous push and pop -> no overflow.
REQ-039 SHALL cover underflow: out_valid in the first RUN cycle -> overflow=1, FAIL, err_count=0.
REQ-040 SHALL cover counter wrap: CNT_W=8, input at counter 250, output at counter 4 -> latency 10.
REQ-041 SHALL cover reset mid-run and empty runs:
- reset low mid-run -> IDLE, all outputs at reset values;
- start with num_patterns=0 -> pass=1 next cycle.
